seg_scan: RTL and testbench
===========================

# seg_scan

Time-multiplexed scanner for the board's multi-digit seven-segment display, sitting directly upstream of the `seg` nibble decoder. It holds a display word in a tear-free double buffer and walks the digits one slot at a time. For each slot it presents the active digit's nibble on `num_o` (wired to `seg.num`) and drives the active-low anode enables and the decimal point. It also inserts anode dead time between slots to suppress ghosting and optionally blanks leading zeros. The top level forms the segment bus from `seg.light[7:1]` and this block's `dp_n_o`.

## Interface
Parameters:
- `DIGITS`, 8: number of digits; the value width is 4*DIGITS.
- `REFRESH_DIV`, 100000: clock cycles per digit slot. This is 1 ms at 100 MHz.
- `DEAD_CYCLES`, 1000: cycles at the start of each slot with all anodes off. Must satisfy 0 ≤ DEAD_CYCLES < REFRESH_DIV.

Ports:
- `clk`, in, 1: the single clock domain.
- `rst`, in, 1: synchronous reset, active-high (already decided).
- `value_i`, in, 4*DIGITS: display word. Nibble k is digit k; digit 0 is rightmost.
- `dp_i`, in, DIGITS: decimal-point request per digit, 1 = lit.
- `lzb_i`, in, 1: leading-zero blank enable.
- `load_i`, in, 1: single-cycle strobe that captures `value_i`, `dp_i` and `lzb_i`.
- `num_o`, out, 4: nibble for `seg`.
- `an_n_o`, out, DIGITS: anode enables, active-low.
- `dp_n_o`, out, 1: decimal point, active-low.
- `frame_o`, out, 1: one-cycle pulse on the first cycle of each frame.
- `pend_o`, out, 1: high while a captured word is waiting for the next frame boundary.

## Operation
- **Counters:**
  - `cnt` counts 0..REFRESH_DIV-1, then wraps to 0.
  - `idx` counts 0..DIGITS-1 and advances when `cnt` wraps.
  - A frame boundary is the edge where `cnt`=REFRESH_DIV-1 and `idx`=DIGITS-1.
- **Buffers:**
  - `load_i` writes the pending set (`value`, `dp`, `lzb`) and sets `pend_o`.
  - A later load before the boundary overwrites the pending set; the last load wins.
  - At a frame boundary with `pend_o`=1, the active set takes the pending set and `pend_o` clears.
  - If `load_i` coincides with a boundary, the active set takes the inputs directly and `pend_o` stays 0.
  - The active set never changes mid-frame.
- **Blanking:** digit k is blanked when active `lzb`=1, k≠0, and active nibbles k..DIGITS-1 are all zero. Digit 0 is never blanked.
- **Per-cycle outputs** (from the current `idx` and `cnt`):
  - `num_o` equals active nibble[`idx`] for the whole slot, including dead time.
  - If `cnt` < DEAD_CYCLES or digit `idx` is blanked: `an_n_o` is all ones and `dp_n_o`=1.
  - Otherwise: `an_n_o` = ~(1<<`idx`) and `dp_n_o` = ~active `dp`[`idx`].
  - At most one `an_n_o` bit is low in any cycle.

## Timing
- **Reset values:** all outputs and state are registered. On the cycle after `rst` is sampled high:
  - `cnt`=0, `idx`=0.
  - Active and pending sets = 0; `pend_o`=0.
  - `num_o`=0, `an_n_o`=all ones, `dp_n_o`=1, `frame_o`=0.
- **Reset priority:** `rst` mid-frame aborts the frame and discards any pending load. `rst` overrides a simultaneous `load_i`.
- **Output alignment:** outputs are computed from next-state values, so they change on the same edge as `cnt` and `idx`. There is no extra pipeline delay.
- **Frame timing:**
  - `frame_o` is high exactly in the cycle where `cnt`=0 and `idx`=0, starting from the first frame boundary after reset. It stays 0 in the cycle immediately after reset.
  - Frame length is DIGITS*REFRESH_DIV cycles.
- **Load latency:** a load appears on the outputs from the first cycle of the next frame. The worst case is one full frame plus one cycle.
- **DEAD_CYCLES=0:** an anode is on for the full slot.

## Structure
- **Shared package `seg_pkg`:** holds the default constants (DIGITS, REFRESH_DIV, DEAD_CYCLES) and the `seg_bus_t` struct (`value`, `dp`, `lzb`) used for both the pending and active sets.
- **Sub-module `seg_scan_tick`:** contains the `cnt`/`idx` counters and emits `slot_last`, `frame_last` and `dead` flags.
- **Top module `seg_scan`:** holds the buffers, the blank logic and the output registers.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2, with cycle 0 as the first cycle after reset release.
- **Reset idle:**
  - Cycles 0–1: `an_n_o`=4'b1111.
  - Cycles 2–7: `an_n_o`=4'b1110 with `num_o`=0.
  - Cycle 8: `idx`=1.
  - Cycle 32: `frame_o`=1.
- **Load with boundary wait:**
  - `load_i` with 16'h1234 at cycle 3 → `pend_o`=1 for cycles 4–31.
  - Cycles 32–39: `num_o`=4.
  - Cycles 56–63: `num_o`=1 with `an_n_o`=4'b0111 on cycles 58–63.
- **Leading-zero blanking:**
  - Load 16'h0050 with `lzb_i`=1 → digits 0 and 1 are shown (`num_o` 0 and 5).
  - Slots for `idx` 2 and 3 keep `an_n_o`=4'b1111 for all 8 cycles.
  - Load 16'h0000 with `lzb_i`=1 → only digit 0 is lit.
- **Load races:**
  - Loads of 16'hAAAA at cycle 5 then 16'hBBBB at cycle 9 → the frame from cycle 32 shows 16'hBBBB.
  - A load at cycle 31 (the boundary) → 16'hBBBB is shown from cycle 32, with `pend_o` never asserted.
- **Decimal point:** `dp_i`=4'b0100 → `dp_n_o`=0 only on cycles 2–7 of the `idx`=2 slot, and 1 everywhere else.
- **Reset mid-frame:**
  - Load, then `rst` at cycle 13 → from cycle 14 the reset values hold and `pend_o`=0.
  - After release, the display shows 16'h0000.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: constants and types shared by the seven-segment scanner files.
//   DEF_*        default parameter values for seg_scan (8 digits, 1 ms slot
//                at 100 MHz, 10 us anode dead time)
//   MAX_DIGITS   widest display the shared buffer type can hold
//   seg_bus_t    one display set (value, decimal points, leading-zero blank)
//                used for both the pending and the active buffer
//   blank_mask   per-digit leading-zero blanking mask for a display value
package seg_pkg;

    localparam int DEF_DIGITS      = 8;
    localparam int DEF_REFRESH_DIV = 100000;
    localparam int DEF_DEAD_CYCLES = 1000;

    // Buffer type is sized for the widest supported display. Narrower
    // instances zero-fill the upper digits, and zero nibbles there never
    // affect the blanking decision.
    localparam int MAX_DIGITS = 16;
    localparam int MAX_IDX_W  = 4;
    localparam int MAX_VAL_W  = 4 * MAX_DIGITS;

    typedef struct packed {
        logic [MAX_VAL_W-1:0]  value;
        logic [MAX_DIGITS-1:0] dp;
        logic                  lzb;
    } seg_bus_t;

    // Bit k set means digit k is dark: blanking enabled, k is not the units
    // digit, and nibble k together with every nibble above it is zero.
    function automatic logic [MAX_DIGITS-1:0] blank_mask(
        input logic [MAX_VAL_W-1:0] value,
        input logic                 lzb
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  zero_above;
        mask       = {MAX_DIGITS{1'b0}};
        zero_above = 1'b1;
        for (int k = MAX_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above & (value[4*k +: 4] == 4'h0);
            mask[k]    = (k != 0) && lzb && zero_above;
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg_scan_tick.sv
// seg_scan_tick: slot and digit timebase for the display scanner.
//   clk, rst          clock and synchronous active-high reset
//   o_cnt_nxt         value the cycle-in-slot counter takes on the next edge
//   o_idx_nxt         value the digit index takes on the next edge
//   o_slot_last       current cycle is the last of a digit slot
//   o_frame_last      current cycle is the last of the last slot (frame edge)
//   o_dead_nxt        next cycle falls inside the anode dead-time window
// Next-state values are exported so the scanner can register its outputs in
// step with the counters rather than one cycle behind them.
module seg_scan_tick
    import seg_pkg::*;
#(
    parameter int DIGITS      = DEF_DIGITS,
    parameter int REFRESH_DIV = DEF_REFRESH_DIV,
    parameter int DEAD_CYCLES = DEF_DEAD_CYCLES,
    localparam int CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1,
    localparam int IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] o_cnt_nxt,
    output logic [IDX_W-1:0] o_idx_nxt,
    output logic             o_slot_last,
    output logic             o_frame_last,
    output logic             o_dead_nxt
);

    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_slot_last;
    logic             w_idx_last;

    assign w_slot_last  = (r_cnt == CNT_W'(REFRESH_DIV - 1));
    assign w_idx_last   = (r_idx == IDX_W'(DIGITS - 1));
    assign o_slot_last  = w_slot_last;
    assign o_frame_last = w_slot_last && w_idx_last;
    assign o_cnt_nxt    = w_cnt_nxt;
    assign o_idx_nxt    = w_idx_nxt;

    // Next counter values; reset is folded in so consumers see 0/0 too.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_idx_nxt = r_idx;
        if (rst) begin
            w_cnt_nxt = {CNT_W{1'b0}};
            w_idx_nxt = {IDX_W{1'b0}};
        end else if (w_slot_last) begin
            w_cnt_nxt = {CNT_W{1'b0}};
            if (w_idx_last) begin
                w_idx_nxt = {IDX_W{1'b0}};
            end else begin
                w_idx_nxt = r_idx + IDX_W'(1'b1);
            end
        end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1'b1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= {CNT_W{1'b0}};
            r_idx <= {IDX_W{1'b0}};
        end else begin
            r_cnt <= w_cnt_nxt;
            r_idx <= w_idx_nxt;
        end
    end

    // With no dead time the comparison would be constant-false, so skip it.
    generate
        if (DEAD_CYCLES == 0) begin : g_no_dead
            assign o_dead_nxt = 1'b0;
        end else begin : g_dead
            assign o_dead_nxt = (w_cnt_nxt < CNT_W'(DEAD_CYCLES));
        end
    endgenerate

endmodule

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed scanner for a multi-digit seven-segment display.
//   clk, rst   clock and synchronous active-high reset
//   value_i    display word, nibble k drives digit k (digit 0 rightmost)
//   dp_i       decimal-point request per digit, 1 = lit
//   lzb_i      leading-zero blank enable
//   load_i     one-cycle strobe capturing value_i, dp_i, lzb_i
//   num_o      nibble of the digit being scanned (to the segment decoder)
//   an_n_o     active-low anode enables, at most one low at a time
//   dp_n_o     active-low decimal point
//   frame_o    one-cycle pulse on the first cycle of every frame
//   pend_o     a captured word is waiting for the next frame boundary
// Loads land in a pending buffer and are promoted to the active buffer only
// at a frame boundary, so a frame is never drawn from two different words.
// Supports up to MAX_DIGITS digits.
module seg_scan
    import seg_pkg::*;
#(
    parameter int DIGITS      = DEF_DIGITS,
    parameter int REFRESH_DIV = DEF_REFRESH_DIV,
    parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic                  lzb_i,
    input  logic                  load_i,
    output logic [3:0]            num_o,
    output logic [DIGITS-1:0]     an_n_o,
    output logic                  dp_n_o,
    output logic                  frame_o,
    output logic                  pend_o
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic                  w_slot_last;
    logic                  w_frame_last;
    logic                  w_dead_nxt;

    seg_bus_t              r_act;
    seg_bus_t              r_pend;
    seg_bus_t              w_in;
    seg_bus_t              w_act_nxt;

    logic [MAX_IDX_W-1:0]  w_sel;
    logic [MAX_DIGITS-1:0] w_blank;
    logic [3:0]            w_num_nxt;
    logic [DIGITS-1:0]     w_an_nxt;
    logic                  w_dp_n_nxt;

    seg_scan_tick #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_tick (
        .clk          (clk),
        .rst          (rst),
        .o_cnt_nxt    (w_cnt_nxt),
        .o_idx_nxt    (w_idx_nxt),
        .o_slot_last  (w_slot_last),
        .o_frame_last (w_frame_last),
        .o_dead_nxt   (w_dead_nxt)
    );

    // The slot counter itself is only needed inside the timebase.
    logic w_cnt_unused;
    assign w_cnt_unused = ^w_cnt_nxt;

    // Widen the input word into the shared buffer format.
    always_comb begin
        w_in       = '0;
        w_in.value = MAX_VAL_W'(value_i);
        w_in.dp    = MAX_DIGITS'(dp_i);
        w_in.lzb   = lzb_i;
    end

    // Active set for the next cycle: it only moves at a frame boundary, and a
    // load arriving exactly on the boundary bypasses the pending buffer.
    always_comb begin
        w_act_nxt = r_act;
        if (w_frame_last) begin
            if (load_i) begin
                w_act_nxt = w_in;
            end else if (pend_o) begin
                w_act_nxt = r_pend;
            end else begin
                w_act_nxt = r_act;
            end
        end else begin
            w_act_nxt = r_act;
        end
    end

    // Next-cycle display outputs, derived from next-state counters and set.
    always_comb begin
        w_sel     = MAX_IDX_W'(w_idx_nxt);
        w_blank   = blank_mask(w_act_nxt.value, w_act_nxt.lzb);
        w_num_nxt = w_act_nxt.value[{w_sel, 2'b00} +: 4];
        if (w_dead_nxt || w_blank[w_sel]) begin
            w_an_nxt   = {DIGITS{1'b1}};
            w_dp_n_nxt = 1'b1;
        end else begin
            w_an_nxt   = ~(DIGITS'(1'b1) << w_idx_nxt);
            w_dp_n_nxt = ~w_act_nxt.dp[w_sel];
        end
    end

    // Buffers, pending flag and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act   <= '0;
            r_pend  <= '0;
            pend_o  <= 1'b0;
            num_o   <= 4'h0;
            an_n_o  <= {DIGITS{1'b1}};
            dp_n_o  <= 1'b1;
            frame_o <= 1'b0;
        end else begin
            r_act <= w_act_nxt;
            if (w_frame_last) begin
                pend_o <= 1'b0;
            end else if (load_i) begin
                pend_o <= 1'b1;
                r_pend <= w_in;
            end else begin
                pend_o <= pend_o;
            end
            // The nibble only changes where the digit index does.
            if (w_slot_last) begin
                num_o <= w_num_nxt;
            end else begin
                num_o <= num_o;
            end
            an_n_o  <= w_an_nxt;
            dp_n_o  <= w_dp_n_nxt;
            frame_o <= w_frame_last;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed, table-driven bench for seg_scan with DIGITS=4,
// REFRESH_DIV=8, DEAD_CYCLES=2, plus a DEAD_CYCLES=0 instance on the same
// inputs. Each scenario fills a stimulus table and a check table keyed by
// cycle number (cycle 0 = first cycle after reset release), then replays them.
module tb_seg_scan;

    logic        clk;
    logic        rst;
    logic [15:0] value_i;
    logic [3:0]  dp_i;
    logic        lzb_i;
    logic        load_i;
    logic [3:0]  num_o, num0_o;
    logic [3:0]  an_n_o, an0_n_o;
    logic        dp_n_o, dp0_n_o;
    logic        frame_o, frame0_o;
    logic        pend_o, pend0_o;

    seg_scan #(.DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .value_i(value_i), .dp_i(dp_i), .lzb_i(lzb_i),
        .load_i(load_i), .num_o(num_o), .an_n_o(an_n_o), .dp_n_o(dp_n_o),
        .frame_o(frame_o), .pend_o(pend_o)
    );

    seg_scan #(.DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .value_i(value_i), .dp_i(dp_i), .lzb_i(lzb_i),
        .load_i(load_i), .num_o(num0_o), .an_n_o(an0_n_o), .dp_n_o(dp0_n_o),
        .frame_o(frame0_o), .pend_o(pend0_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        rst;
        logic        load;
        logic [15:0] value;
        logic [3:0]  dp;
        logic        lzb;
    } stim_t;

    typedef struct {
        int          cyc;
        logic [5:0]  care;
        logic [3:0]  num;
        logic [3:0]  an;
        logic        dp_n;
        logic        frame;
        logic        pend;
        logic [3:0]  an0;
    } chk_t;

    localparam logic [5:0] C_NUM = 6'b000001;
    localparam logic [5:0] C_AN  = 6'b000010;
    localparam logic [5:0] C_DP  = 6'b000100;
    localparam logic [5:0] C_FR  = 6'b001000;
    localparam logic [5:0] C_PD  = 6'b010000;
    localparam logic [5:0] C_AN0 = 6'b100000;

    stim_t stim[$];
    chk_t  chk[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    string scn;

    function automatic void add_ld(int c, logic [15:0] v, logic [3:0] d, logic z);
        stim.push_back('{c, 1'b0, 1'b1, v, d, z});
    endfunction

    function automatic void add_rst(int c);
        stim.push_back('{c, 1'b1, 1'b0, 16'h0000, 4'h0, 1'b0});
    endfunction

    function automatic void ck(int c, logic [5:0] care, logic [3:0] num, logic [3:0] an,
                               logic dp_n, logic fr, logic pd, logic [3:0] an0);
        chk.push_back('{c, care, num, an, dp_n, fr, pd, an0});
    endfunction

    task automatic cmp(input string name, input int c, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s/%s cyc=%0d got=%h expected=%h", scn, name, c, act, exp);
        end
    endtask

    // Reset, then replay the stimulus table and compare against the check table.
    task automatic run_scn(input int ncyc);
        rst = 1'b1; load_i = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < ncyc; c++) begin
            rst = 1'b0; load_i = 1'b0;
            value_i = 16'hFFFF; dp_i = 4'hF; lzb_i = 1'b1;   // ignored without load
            foreach (stim[i]) begin
                if (stim[i].cyc == c) begin
                    rst = stim[i].rst; load_i = stim[i].load;
                    value_i = stim[i].value; dp_i = stim[i].dp; lzb_i = stim[i].lzb;
                end
            end
            @(negedge clk);
            foreach (chk[i]) begin
                if (chk[i].cyc == c) begin
                    if (chk[i].care[0]) cmp("num", c, num_o, chk[i].num);
                    if (chk[i].care[1]) cmp("an", c, an_n_o, chk[i].an);
                    if (chk[i].care[2]) cmp("dp", c, {3'b000, dp_n_o}, {3'b000, chk[i].dp_n});
                    if (chk[i].care[3]) cmp("frame", c, {3'b000, frame_o}, {3'b000, chk[i].frame});
                    if (chk[i].care[4]) cmp("pend", c, {3'b000, pend_o}, {3'b000, chk[i].pend});
                    if (chk[i].care[5]) cmp("an_dead0", c, an0_n_o, chk[i].an0);
                end
            end
            @(posedge clk); #1;
        end
        stim.delete();
        chk.delete();
    endtask

    initial begin
        rst = 1'b1; load_i = 1'b0; value_i = 16'h0000; dp_i = 4'h0; lzb_i = 1'b0;

        // Reset state and idle scan.
        scn = "idle";
        ck(0, C_NUM|C_AN|C_DP|C_FR|C_PD|C_AN0, 4'h0, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b1111);
        ck(1, C_AN|C_AN0, 4'h0, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b1110);
        for (int c = 2; c < 8; c++) ck(c, C_NUM|C_AN|C_DP, 4'h0, 4'b1110, 1'b1, 1'b0, 1'b0, 4'h0);
        ck(8, C_AN|C_AN0, 4'h0, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b1101);
        ck(10, C_AN, 4'h0, 4'b1101, 1'b1, 1'b0, 1'b0, 4'h0);
        ck(31, C_FR|C_AN0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'b0111);
        ck(32, C_FR, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0);
        ck(33, C_FR, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        run_scn(34);

        // Load waits for the frame boundary.
        scn = "load_wait";
        add_ld(3, 16'h1234, 4'h0, 1'b0);
        ck(3, C_PD, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        for (int c = 4; c < 32; c++) ck(c, C_PD, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0);
        ck(24, C_NUM, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        ck(32, C_PD, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        for (int c = 32; c < 40; c++) ck(c, C_NUM, 4'h4, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        ck(40, C_NUM, 4'h3, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        ck(48, C_NUM, 4'h2, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        for (int c = 56; c < 64; c++)
            ck(c, C_NUM|C_AN, 4'h1, (c < 58) ? 4'b1111 : 4'b0111, 1'b1, 1'b0, 1'b0, 4'h0);
        run_scn(64);

        // Leading-zero blanking, including the all-zero word.
        scn = "lzb";
        add_ld(0, 16'h0050, 4'h0, 1'b1);
        add_ld(40, 16'h0000, 4'h0, 1'b1);
        ck(34, C_NUM|C_AN, 4'h0, 4'b1110, 1'b1, 1'b0, 1'b0, 4'h0);
        ck(42, C_NUM|C_AN, 4'h5, 4'b1101, 1'b1, 1'b0, 1'b0, 4'h0);
        ck(50, C_NUM, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        for (int c = 48; c < 64; c++) ck(c, C_AN, 4'h0, 4'b1111, 1'b1, 1'b0, 1'b0, 4'h0);
        ck(66, C_AN, 4'h0, 4'b1110, 1'b1, 1'b0, 1'b0, 4'h0);
        ck(74, C_AN, 4'h0, 4'b1111, 1'b1, 1'b0, 1'b0, 4'h0);
        ck(82, C_AN, 4'h0, 4'b1111, 1'b1, 1'b0, 1'b0, 4'h0);
        ck(90, C_AN, 4'h0, 4'b1111, 1'b1, 1'b0, 1'b0, 4'h0);
        run_scn(96);

        // Two loads before the boundary: the last one wins.
        scn = "last_wins";
        add_ld(5, 16'hAAAA, 4'h0, 1'b0);
        add_ld(9, 16'hBBBB, 4'h0, 1'b0);
        ck(10, C_PD, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0);
        ck(20, C_NUM, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        ck(32, C_NUM|C_PD, 4'hB, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        ck(40, C_NUM, 4'hB, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        ck(48, C_NUM, 4'hB, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        ck(56, C_NUM, 4'hB, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        run_scn(64);

        // Load exactly on the boundary bypasses the pending buffer.
        scn = "edge_load";
        add_ld(31, 16'hBBBB, 4'h0, 1'b0);
        for (int c = 0; c < 41; c++) ck(c, C_PD, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        ck(31, C_NUM, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        ck(32, C_NUM, 4'hB, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        ck(40, C_NUM, 4'hB, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        run_scn(41);

        // Decimal point lit only outside dead time of its own slot.
        scn = "dp";
        add_ld(0, 16'h0000, 4'b0100, 1'b0);
        ck(20, C_DP, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        for (int c = 32; c < 64; c++)
            ck(c, C_DP, 4'h0, 4'h0, (c >= 50 && c <= 55) ? 1'b0 : 1'b1, 1'b0, 1'b0, 4'h0);
        ck(50, C_AN, 4'h0, 4'b1011, 1'b1, 1'b0, 1'b0, 4'h0);
        run_scn(64);

        // Reset mid-frame aborts the frame and drops the pending load.
        scn = "rst_mid";
        add_ld(3, 16'h1234, 4'h0, 1'b0);
        add_rst(13);
        ck(12, C_PD, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0);
        ck(14, C_NUM|C_AN|C_DP|C_FR, 4'h0, 4'b1111, 1'b1, 1'b0, 1'b0, 4'h0);
        for (int c = 14; c < 78; c++) ck(c, C_PD, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        ck(16, C_AN, 4'h0, 4'b1110, 1'b1, 1'b0, 1'b0, 4'h0);
        ck(32, C_FR, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        ck(45, C_FR, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        ck(46, C_FR|C_NUM, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0);
        ck(54, C_NUM, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        ck(62, C_NUM, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        ck(70, C_NUM, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        run_scn(78);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
